// File: rtl/mips32_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : mips32_fetch_queue
// Purpose  : MIPS32 fetch front end, prefetch FIFO feeding decode, with redirect flush
// Revision : 1.0
// ============================================================================
module mips32_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [AW-1:0]          imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   halt,
    output logic                   id_valid,
    output logic [31:0]            id_ir,
    output logic [31:0]            id_npc,
    input  logic                   id_ready,
    output logic [31:0]            pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            c_pw    = $clog2(DEPTH);
    localparam int            c_cw    = c_pw + 1;
    localparam logic [c_cw:0] c_depth = (c_cw + 1)'(DEPTH);

    logic [31:0]     r_pc;
    logic [c_cw-1:0] r_count;
    logic [c_cw-1:0] r_inflight;
    logic [c_cw-1:0] r_discard;
    logic [c_pw-1:0] r_wp;
    logic [c_pw-1:0] r_rp;
    logic [c_pw-1:0] r_tag_wp;
    logic [c_pw-1:0] r_tag_rp;
    logic [31:0]     r_ir  [DEPTH];
    logic [31:0]     r_npc [DEPTH];
    logic [31:0]     r_tag [DEPTH];

    logic [c_cw:0]   w_occ;
    logic            w_req;
    logic            w_grant;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;

    // Credit rule: FIFO slots already used plus those promised to outstanding reads
    assign w_occ   = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_req   = rst_n && !halt && !redirect && (w_occ < c_depth);
    assign w_grant = w_req && imem_gnt;
    assign w_resp  = imem_rvalid && (r_inflight != '0);
    assign w_push  = w_resp && (r_discard == '0) && !redirect;
    assign w_pop   = (r_count != '0) && id_ready && !redirect;

    assign imem_req  = w_req;
    assign imem_addr = r_pc[AW-1:0];
    assign pc        = r_pc;
    assign count     = r_count;
    assign id_valid  = (r_count != '0);
    assign id_ir     = r_ir[r_rp];
    assign id_npc    = r_npc[r_rp];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_tag_wp   <= '0;
            r_tag_rp   <= '0;
        end else begin
            r_inflight <= r_inflight + c_cw'(w_grant) - c_cw'(w_resp);
            if (w_grant)
                r_tag_wp <= r_tag_wp + 1'b1;
            if (w_resp)
                r_tag_rp <= r_tag_rp + 1'b1;
            if (redirect) begin
                // Everything still outstanding after this edge belongs to the old path
                r_pc      <= redirect_pc;
                r_count   <= '0;
                r_wp      <= '0;
                r_rp      <= '0;
                r_discard <= r_inflight - c_cw'(w_resp);
            end else begin
                if (w_grant)
                    r_pc <= r_pc + 32'd1;
                r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
                if (w_push)
                    r_wp <= r_wp + 1'b1;
                if (w_pop)
                    r_rp <= r_rp + 1'b1;
                if (w_resp && (r_discard != '0))
                    r_discard <= r_discard - 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ir[i]  <= '0;
                r_npc[i] <= '0;
            end
        end else if (w_push) begin
            r_ir[r_wp]  <= imem_rdata;
            r_npc[r_wp] <= r_tag[r_tag_rp] + 32'd1;
        end
    end

    // Address tags pair each in-order response with the address that fetched it
    always_ff @(posedge clk1) begin
        if (w_grant)
            r_tag[r_tag_wp] <= r_pc;
    end

endmodule
`default_nettype wire

// File: tb/tb_mips32_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_fetch_queue
// Purpose  : directed vectors and corner sequences for mips32_fetch_queue
// Revision : 1.0
// ============================================================================
module tb_mips32_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic                   clk1        = 1'b0;
    logic                   rst_n       = 1'b0;
    logic                   imem_req;
    logic [AW-1:0]          imem_addr;
    logic                   imem_gnt    = 1'b1;
    logic                   imem_rvalid = 1'b0;
    logic [31:0]            imem_rdata  = '0;
    logic                   redirect    = 1'b0;
    logic [31:0]            redirect_pc = '0;
    logic                   halt        = 1'b0;
    logic                   id_valid;
    logic [31:0]            id_ir;
    logic [31:0]            id_npc;
    logic                   id_ready    = 1'b1;
    logic [31:0]            pc;
    logic [$clog2(DEPTH):0] count;

    int checks   = 0;
    int passes   = 0;
    int lat      = 1;
    int edge_n   = 0;
    int last_due = 0;

    typedef struct {
        logic [AW-1:0] a;
        int            due;
    } pend_t;
    pend_t pend[$];

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [31:0] ir;
        logic [31:0] npc;
        logic [2:0]  cnt;
        logic [31:0] pcv;
        logic        req;
    } vec_t;
    vec_t tbl[20];

    mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .id_valid    (id_valid),
        .id_ir       (id_ir),
        .id_npc      (id_npc),
        .id_ready    (id_ready),
        .pc          (pc),
        .count       (count)
    );

    always #5 clk1 = ~clk1;

    // Memory model: mem[k] = k*16, in-order responses lat edges after the grant
    always @(posedge clk1) begin : mem_accept
        int d;
        edge_n++;
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (imem_rvalid) begin
                if (pend.size() == 0) begin
                    checks++;
                    $display("FAIL protocol: response with nothing outstanding at edge %0d", edge_n);
                end else begin
                    void'(pend.pop_front());
                end
            end
            if (imem_req && imem_gnt) begin
                d = edge_n + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend.push_back('{imem_addr, d});
            end
        end
    end

    always @(negedge clk1) begin
        if (rst_n && pend.size() > 0 && pend[0].due <= edge_n + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'(pend[0].a) * 32'd16;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    endtask

    // Asserts reset mid-cycle, checks the cleared state, releases at a negedge (cycle 0)
    task automatic do_reset();
        @(negedge clk1);
        rst_n    = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        #1;
        chk("rst count",    32'(count),    32'd0);
        chk("rst pc",       pc,            32'd0);
        chk("rst id_valid", 32'(id_valid), 32'd0);
        chk("rst imem_req", 32'(imem_req), 32'd0);
        chk("rst id_ir",    id_ir,         32'd0);
        chk("rst id_npc",   id_npc,        32'd0);
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(negedge clk1);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Streaming at latency 1, then backpressure until full, then drain
        for (int k = 0; k < 20; k++)
            tbl[k] = '{1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 32'(k), 1'b1};
        for (int k = 2; k <= 10; k++)
            tbl[k] = '{1'b1, 1'b1, 32'((k - 2) * 16), 32'(k - 1), 3'd1, 32'(k), 1'b1};
        tbl[10].rdy = 1'b0;
        tbl[11] = '{1'b0, 1'b1, 32'h80, 32'd9,  3'd2, 32'd11, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 32'h80, 32'd9,  3'd3, 32'd12, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'h80, 32'd9,  3'd4, 32'd12, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 32'h80, 32'd9,  3'd4, 32'd12, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 32'h80, 32'd9,  3'd4, 32'd12, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 32'h90, 32'd10, 3'd3, 32'd12, 1'b1};
        tbl[17] = '{1'b1, 1'b1, 32'hA0, 32'd11, 3'd2, 32'd13, 1'b1};
        tbl[18] = '{1'b1, 1'b1, 32'hB0, 32'd12, 3'd2, 32'd14, 1'b1};
        tbl[19] = '{1'b1, 1'b1, 32'hC0, 32'd13, 3'd2, 32'd15, 1'b1};

        lat = 1;
        imem_gnt = 1'b1;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk1);
            id_ready = tbl[k].rdy;
            #1;
            chk($sformatf("tbl%0d id_valid", k), 32'(id_valid), 32'(tbl[k].vld));
            if (tbl[k].vld) begin
                chk($sformatf("tbl%0d id_ir", k),  id_ir,  tbl[k].ir);
                chk($sformatf("tbl%0d id_npc", k), id_npc, tbl[k].npc);
            end
            chk($sformatf("tbl%0d count", k),    32'(count),    32'(tbl[k].cnt));
            chk($sformatf("tbl%0d pc", k),       pc,            tbl[k].pcv);
            chk($sformatf("tbl%0d imem_req", k), 32'(imem_req), 32'(tbl[k].req));
        end

        // Latency 3: redirect to 0x40 with three reads outstanding
        lat = 3;
        id_ready = 1'b1;
        do_reset();
        #1;
        chk("r3 c0 imem_req", 32'(imem_req), 32'd1);
        step();
        step();
        @(negedge clk1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("r3 redirect imem_req", 32'(imem_req), 32'd0);
        @(negedge clk1);
        redirect = 1'b0;
        #1;
        chk("r3 c4 pc",       pc,            32'h40);
        chk("r3 c4 imem_req", 32'(imem_req), 32'd1);
        chk("r3 c4 count",    32'(count),    32'd0);
        for (int c = 5; c <= 7; c++) begin
            step();
            chk($sformatf("r3 c%0d no stale", c), 32'(id_valid), 32'd0);
        end
        step();
        chk("r3 c8 id_valid", 32'(id_valid), 32'd1);
        chk("r3 c8 id_ir",    id_ir,         32'h400);
        chk("r3 c8 id_npc",   id_npc,        32'h41);
        step();
        chk("r3 c9 id_ir",    id_ir,         32'h410);
        chk("r3 c9 id_npc",   id_npc,        32'h42);

        // Latency 2: redirect coincides with a response and a pop
        lat = 2;
        do_reset();
        step();
        step();
        @(negedge clk1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("r2 c3 id_valid", 32'(id_valid), 32'd1);
        chk("r2 c3 id_ir",    id_ir,         32'h0);
        chk("r2 c3 rvalid",   32'(imem_rvalid), 32'd1);
        @(negedge clk1);
        redirect = 1'b0;
        #1;
        chk("r2 c4 count",    32'(count),    32'd0);
        chk("r2 c4 id_valid", 32'(id_valid), 32'd0);
        chk("r2 c4 pc",       pc,            32'h100);
        step();
        chk("r2 c5 no stale", 32'(id_valid), 32'd0);
        step();
        chk("r2 c6 no stale", 32'(id_valid), 32'd0);
        step();
        chk("r2 c7 id_valid", 32'(id_valid), 32'd1);
        chk("r2 c7 id_ir",    id_ir,         32'h1000);
        chk("r2 c7 id_npc",   id_npc,        32'h101);

        // halt with two buffered entries
        lat = 1;
        do_reset();
        id_ready = 1'b0;
        step();
        @(negedge clk1);
        halt = 1'b1;
        #1;
        chk("h c2 imem_req", 32'(imem_req), 32'd0);
        step();
        chk("h c3 count",    32'(count),    32'd2);
        chk("h c3 imem_req", 32'(imem_req), 32'd0);
        id_ready = 1'b1;
        step();
        chk("h c4 count",    32'(count),    32'd1);
        chk("h c4 id_ir",    id_ir,         32'h10);
        chk("h c4 id_npc",   id_npc,        32'd2);
        chk("h c4 imem_req", 32'(imem_req), 32'd0);
        @(negedge clk1);
        #1;
        chk("h c5 count",    32'(count),    32'd0);
        chk("h c5 id_valid", 32'(id_valid), 32'd0);
        chk("h c5 pc",       pc,            32'd2);
        halt = 1'b0;
        #1;
        chk("h c5 resume req",  32'(imem_req),  32'd1);
        chk("h c5 resume addr", 32'(imem_addr), 32'd2);
        step();
        step();
        chk("h c7 id_ir",  id_ir,  32'h20);
        chk("h c7 id_npc", id_npc, 32'd3);

        // pc wrap at 0xFFFFFFFF
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        #1;
        chk("w c0 imem_req", 32'(imem_req), 32'd0);
        @(negedge clk1);
        redirect = 1'b0;
        #1;
        chk("w c1 pc",        pc,             32'hFFFF_FFFF);
        chk("w c1 imem_addr", 32'(imem_addr), 32'h3FF);
        chk("w c1 imem_req",  32'(imem_req),  32'd1);
        step();
        chk("w c2 pc",        pc,             32'd0);
        chk("w c2 imem_addr", 32'(imem_addr), 32'd0);
        step();
        chk("w c3 id_valid",  32'(id_valid),  32'd1);
        chk("w c3 id_ir",     id_ir,          32'h3FF0);
        chk("w c3 id_npc",    id_npc,         32'd0);
        step();
        chk("w c4 id_ir",     id_ir,          32'h0);
        chk("w c4 id_npc",    id_npc,         32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
